// File: rtl/rot_seq_ctrl.sv
// rot_seq_ctrl
//   Sequences repeated right-rotations of one byte through an external
//   combinational 8-bit rotator, one rotation per clock.
//   Jobs arrive on a valid/ready input; each result is held on a
//   valid/ready output until it is consumed.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   in_valid   job request valid
//   in_ready   job accepted when in_valid && in_ready on a rising edge
//   in_data    byte to rotate
//   in_amt     rotate amount applied per step
//   in_reps    number of rotate steps (0..15)
//   rot_in     data driven to the rotator
//   rot_sel    amount driven to the rotator (0 outside RUN)
//   rot_out    rotator result, rot_out[i] = rot_in[(i+rot_sel) mod 8]
//   out_valid  result valid
//   out_ready  result consumed when out_valid && out_ready on a rising edge
//   out_data   rotated result
//   out_steps  steps executed for the current result (= accepted in_reps)
//   busy       high while a job is running or its result is pending
module rot_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [2:0] in_amt,
  input  logic [3:0] in_reps,
  output logic [7:0] rot_in,
  output logic [2:0] rot_sel,
  input  logic [7:0] rot_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [3:0] out_steps,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;

  logic [7:0] work;
  logic [2:0] amt;
  logic [3:0] reps;
  logic [3:0] cnt;

  logic       accept;
  logic       last_step;

  // Handshake outputs come from registered state only; rst_n gates them
  // so nothing is offered while reset is being applied.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = rst_n && (state_q == DONE);
  assign busy      = rst_n && ((state_q == RUN) || (state_q == DONE));

  assign accept    = in_valid && in_ready;
  // reps is never 0 in RUN, so reps-1 does not underflow and cnt never wraps.
  assign last_step = (cnt == (reps - 4'd1));

  assign rot_in  = work;
  assign rot_sel = (state_q == RUN) ? amt : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (in_reps == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work      <= '0;
      amt       <= '0;
      reps      <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_steps <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            work <= in_data;
            amt  <= in_amt;
            reps <= in_reps;
            cnt  <= '0;
            // A zero-step job is its own result.
            if (in_reps == 4'd0) begin
              out_data  <= in_data;
              out_steps <= '0;
            end
          end
        end
        RUN: begin
          work <= rot_out;
          cnt  <= cnt + 4'd1;
          if (last_step) begin
            out_data  <= rot_out;
            out_steps <= reps;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rot_seq_ctrl.sv
module tb_rot_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [3:0] in_reps;
  logic [7:0] rot_in;
  logic [2:0] rot_sel;
  logic [7:0] rot_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_steps;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rot_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_reps   (in_reps),
    .rot_in    (rot_in),
    .rot_sel   (rot_sel),
    .rot_out   (rot_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_steps (out_steps),
    .busy      (busy)
  );

  // Downstream rotator: rot_out[i] = rot_in[(i+rot_sel) mod 8].
  always_comb begin
    rot_out = '0;
    for (int i = 0; i < 8; i++) begin
      rot_out[i] = rot_in[(i + int'(rot_sel)) % 8];
    end
  end

  // Reference: rotate right by n single-bit steps.
  function automatic logic [7:0] ror_model(input logic [7:0] v, input int unsigned n);
    logic [7:0] t;
    t = v;
    repeat (n) t = {t[0], t[7:1]};
    return t;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic [2:0] amt;
    logic [3:0] reps;
    int         hold;
    logic [7:0] exp_data;
    logic [3:0] exp_steps;
  } vec_t;

  vec_t vecs[7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete job: accept, run, optional back-pressure, handshake.
  task automatic run_job(input string tag, input logic [7:0] d, input logic [2:0] a,
                         input logic [3:0] r, input int hold,
                         input logic [7:0] ed, input logic [3:0] es);
    int lat;
    int nsel;
    int bad;
    chk({tag, ".in_ready_idle"}, 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_reps  = r;
    tick;
    in_valid = 1'b0;
    in_data  = '0;
    in_amt   = '0;
    in_reps  = '0;
    lat  = 0;
    nsel = 0;
    while (!out_valid && lat < 40) begin
      if (rot_sel == a && busy && !in_ready) nsel++;
      tick;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(r));
    chk({tag, ".run_sel_cycles"}, 32'(nsel), 32'(r));
    chk({tag, ".out_valid"}, 32'(out_valid), 1);
    chk({tag, ".out_data"}, 32'(out_data), 32'(ed));
    chk({tag, ".out_steps"}, 32'(out_steps), 32'(es));
    chk({tag, ".rot_sel_done"}, 32'(rot_sel), 0);
    // Offer a decoy job while the result waits; it must not be taken.
    in_valid = 1'b1;
    in_data  = ~d;
    in_amt   = a + 3'd1;
    in_reps  = 4'd1;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      tick;
      if (out_data !== ed || out_steps !== es || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    if (hold > 0) chk({tag, ".hold_stable"}, 32'(bad), 0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, ".post_hs_valid"}, 32'(out_valid), 0);
    chk({tag, ".post_hs_ready"}, 32'(in_ready), 1);
    chk({tag, ".post_hs_busy"}, 32'(busy), 0);
    chk({tag, ".retain_data"}, 32'(out_data), 32'(ed));
    chk({tag, ".retain_steps"}, 32'(out_steps), 32'(es));
    in_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vecs[0] = '{8'h81, 3'd1, 4'd3,  0, 8'h30, 4'd3};
    vecs[1] = '{8'hA5, 3'd5, 4'd0,  0, 8'hA5, 4'd0};
    vecs[2] = '{8'h0F, 3'd2, 4'd15, 0, 8'h3C, 4'd15};
    vecs[3] = '{8'h01, 3'd7, 4'd8,  1, 8'h01, 4'd8};
    vecs[4] = '{8'h96, 3'd3, 4'd1,  5, 8'hD2, 4'd1};
    vecs[5] = '{8'h12, 3'd4, 4'd2,  2, 8'h12, 4'd2};
    vecs[6] = '{8'h80, 3'd1, 4'd15, 0, 8'h01, 4'd15};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    in_amt    = 3'd1;
    in_reps   = 4'd1;
    out_ready = 1'b1;
    tick;
    tick;
    chk("reset.in_ready", 32'(in_ready), 0);
    chk("reset.out_valid", 32'(out_valid), 0);
    chk("reset.busy", 32'(busy), 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    #1;
    chk("reset.first_ready", 32'(in_ready), 1);
    chk("reset.out_data", 32'(out_data), 0);
    chk("reset.out_steps", 32'(out_steps), 0);
    chk("reset.rot_in", 32'(rot_in), 0);
    chk("reset.rot_sel", 32'(rot_sel), 0);

    for (int v = 0; v < 7; v++) begin
      run_job($sformatf("vec%0d", v), vecs[v].data, vecs[v].amt, vecs[v].reps,
              vecs[v].hold, vecs[v].exp_data, vecs[v].exp_steps);
    end

    // Abort a reps=6 job with a one-edge reset after its first RUN step.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    in_amt   = 3'd3;
    in_reps  = 4'd6;
    tick;
    in_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    chk("abort.ready_in_reset", 32'(in_ready), 0);
    chk("abort.busy_in_reset", 32'(busy), 0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("abort.in_ready", 32'(in_ready), 1);
    chk("abort.out_valid", 32'(out_valid), 0);
    chk("abort.out_data", 32'(out_data), 0);
    chk("abort.out_steps", 32'(out_steps), 0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("abort.no_late_valid", 32'(bad), 0);
    run_job("abort.fresh", 8'h5A, 3'd3, 4'd6, 1, 8'h96, 4'd6);

    // Random jobs with idle gaps and random back-pressure.
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] d;
      logic [2:0] a;
      logic [3:0] r;
      int unsigned gap;
      d   = 8'($urandom);
      a   = 3'($urandom);
      r   = 4'($urandom);
      gap = $urandom_range(0, 3);
      repeat (gap) tick;
      run_job($sformatf("rnd%0d", n), d, a, r, int'($urandom_range(0, 4)),
              ror_model(d, (int'(a) * int'(r)) % 8), r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rot_seq_ctrl.md
ROT_SEQ_CTRL -- requirements
Module: rot_seq_ctrl

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-low, named clk and rst_n.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  job request valid.
REQ-005 SHALL have port in_ready  output  1  job accepted when in_valid and in_ready are both high on a rising edge.
REQ-006 SHALL have port in_data  input  8  byte to rotate.
REQ-007 SHALL have port in_amt  input  3  rotate amount per step.
REQ-008 SHALL have port in_reps  input  4  number of rotate steps, 0..15.
REQ-009 SHALL have port rot_in  output  8  data driven to the downstream 8-bit rotator.
REQ-010 SHALL have port rot_sel  output  3  amount driven to the rotator.
REQ-011 SHALL have port rot_out  input  8  combinational rotator result, rot_out[i] = rot_in[(i+rot_sel) mod 8], a right rotate.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  result consumed when out_valid and out_ready are both high on a rising edge.
REQ-014 SHALL have port out_data  output  8  rotated result.
REQ-015 SHALL have port out_steps  output  4  steps executed for the current result; equals the accepted in_reps.
REQ-016 SHALL have port busy  output  1  high in the RUN and DONE states.

Function
REQ-017 SHALL implement an FSM with states IDLE, RUN and DONE, plus internal registers work[7:0], amt[2:0], reps[3:0] and cnt[3:0].
REQ-018 SHALL in IDLE drive in_ready=1; on accept, latch work=in_data, amt=in_amt, reps=in_reps, cnt=0.
REQ-019 SHALL on accept go to RUN when in_reps!=0, or go directly to DONE with out_data=in_data when in_reps==0.
REQ-020 SHALL in RUN drive rot_in=work and rot_sel=amt.
REQ-021 SHALL on each RUN edge load work=rot_out and increment cnt; exactly one rotation per clock.
REQ-022 SHALL on the RUN edge where cnt==reps-1 load out_data=rot_out and out_steps=reps, and go to DONE.
REQ-023 SHALL outside RUN drive rot_in=work and rot_sel=0.
REQ-024 SHALL assert out_valid while in DONE; out_valid rises on the reps-th rising edge after the accepting edge, or on the accepting edge itself when reps==0.
REQ-025 SHALL in DONE hold out_data and out_steps stable while out_ready is low, for any number of cycles.
REQ-026 SHALL on an out_valid and out_ready edge go to IDLE, so out_valid falls and in_ready rises on that edge.
REQ-027 SHALL keep in_ready=0 in RUN and DONE; in_valid is ignored there, with no queueing.
REQ-028 SHALL not accept in the cycle of an output handshake; this gives a minimum of 1 IDLE cycle between jobs.
REQ-029 SHALL retain out_data and out_steps after the output handshake until the next result loads.
REQ-030 SHALL produce a final result equal to in_data rotated right by (in_amt*in_reps) mod 8.
REQ-031 SHALL give a 4-bit cnt no wrap, since reps is at most 15 and the exit is at cnt==reps-1.
REQ-032 SHALL keep in_ready, out_valid and busy decoded from registered state only, with no combinational path from in_valid or out_ready.

Reset
REQ-033 SHALL when rst_n is low at a rising edge set state=IDLE and set work, amt, reps, cnt, out_data and out_steps to 0.
REQ-034 SHALL force in_ready=0, out_valid=0 and busy=0 combinationally while rst_n is low.
REQ-035 SHALL let a reset asserted in RUN or DONE abort the job; no out_valid follows and the result is discarded.
REQ-036 SHALL have in_ready=1 on the first cycle after rst_n returns high.

Verification
REQ-037 SHALL cover: in_data=0x81, amt=1, reps=3, out_ready=1 -> out_valid 3 edges after accept, out_data=0x30, out_steps=3.
REQ-038 SHALL cover: in_data=0xA5, amt=5, reps=0 -> out_valid on the accept edge, out_data=0xA5, out_steps=0, and rot_sel=0 throughout.
REQ-039 SHALL cover: in_data=0x0F, amt=2, reps=15 -> rot_sel=2 for 15 cycles, out_data=0x3C; also in_data=0x01, amt=7, reps=8 -> out_data=0x01.
REQ-040 SHALL cover: result ready with out_ready held low 5 cycles, in_valid held high -> out_data stable, in_ready=0, no second accept, and accept resumes 1 cycle after the handshake.
REQ-041 SHALL cover: rst_n low for 1 edge at RUN step 2 of a reps=6 job -> next cycle in_ready=1, out_valid=0, out_data=0x00, and a fresh job completes correctly.
REQ-042 SHALL cover: a bench rotator model and a scoreboard checking REQ-030 over 1000 random jobs with random in_valid/out_ready gaps.
